// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store traffic,
// one transaction at a time, with store lane steering, load extension and a watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_err,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [15:0]       WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t      state;
    logic        owner_dm;
    logic        lat_we;
    logic [2:0]  lat_size;
    logic [1:0]  lat_a;
    logic [15:0] wd_cnt;

    logic        dm_legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] lane;
    logic [31:0] ld_ext;

    always_comb begin
        dm_legal = 1'b0;
        case (dm_size)
            3'b000, 3'b100: dm_legal = 1'b1;
            3'b001, 3'b101: dm_legal = ~dm_addr[0];
            3'b010:         dm_legal = (dm_addr[1:0] == 2'b00);
            default:        dm_legal = 1'b0;
        endcase
    end

    // Data port wins in IDLE; an illegal data request still blocks fetch that cycle.
    assign dm_gnt = (state == IDLE) && dm_req && dm_legal;
    assign dm_err = (state == IDLE) && dm_req && !dm_legal;
    assign if_gnt = (state == IDLE) && !dm_req && if_req;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (dm_we) begin
            case (dm_size[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << dm_addr[1:0];
                    st_wdata = {4{dm_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << dm_addr[1:0];
                    st_wdata = {2{dm_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = dm_wdata;
                end
            endcase
        end
    end

    always_comb begin
        lane   = mem_rdata >> {lat_a, 3'b000};
        ld_ext = lane;
        case (lat_size)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_dm    <= 1'b0;
            lat_we      <= 1'b0;
            lat_size    <= 3'b000;
            lat_a       <= 2'b00;
            wd_cnt      <= 16'h0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= 4'h0;
            mem_wdata   <= 32'h0;
            if_rvalid   <= 1'b0;
            if_rdata    <= 32'h0;
            dm_rvalid   <= 1'b0;
            dm_rdata    <= 32'h0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_gnt) begin
                        owner_dm  <= 1'b1;
                        lat_we    <= dm_we;
                        lat_size  <= dm_size;
                        lat_a     <= dm_addr[1:0];
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr & WORD_MASK;
                        mem_be    <= st_be;
                        mem_wdata <= st_wdata;
                        wd_cnt    <= 16'h0;
                        state     <= REQ;
                    end else if (if_gnt) begin
                        owner_dm  <= 1'b0;
                        lat_we    <= 1'b0;
                        lat_size  <= 3'b010;
                        lat_a     <= 2'b00;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr & WORD_MASK;
                        mem_be    <= 4'b1111;
                        mem_wdata <= 32'h0;
                        wd_cnt    <= 16'h0;
                        state     <= REQ;
                    end
                end
                REQ, RESP: begin
                    // Watchdog abort takes precedence; rdata registers are already 0 here.
                    if (wd_cnt == WD_LAST) begin
                        err_timeout <= 1'b1;
                        mem_req     <= 1'b0;
                        if (owner_dm) dm_rvalid <= 1'b1;
                        else          if_rvalid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'h1;
                        if (state == REQ && mem_ready) begin
                            mem_req <= 1'b0;
                            state   <= RESP;
                        end else if (state == RESP && mem_rvalid) begin
                            if (owner_dm) begin
                                dm_rvalid <= 1'b1;
                                dm_rdata  <= lat_we ? 32'h0 : ld_ext;
                            end else begin
                                if_rvalid <= 1'b1;
                                if_rdata  <= mem_rdata;
                            end
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if_rvalid <= 1'b0;
                    dm_rvalid <= 1'b0;
                    if_rdata  <= 32'h0;
                    dm_rdata  <= 32'h0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a word-array memory and byte-level access model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_err, dm_rvalid;
    logic [2:0]  dm_size;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, err_timeout;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] mem_m [int unsigned];

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_err(dm_err),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input int unsigned wa);
        if (!mem_m.exists(wa)) mem_m[wa] = $urandom;
        return mem_m[wa];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from IDLE back to IDLE; dr/dv are extra memory wait cycles.
    task automatic txn(input bit is_dm, input bit we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int dr, input int dv, output logic [31:0] got);
        int          a, nb;
        bit          legal, st;
        logic [31:0] word, exp_be, exp_wd, exp_rd, v;
        a      = int'(addr % 4);
        nb     = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
        legal  = !is_dm || ((size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (addr % nb) == 0);
        st     = is_dm && we;
        got    = 32'h0;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        chk("dm_gnt", dm_gnt, 32'(is_dm && legal));
        chk("if_gnt", if_gnt, 32'(!is_dm));
        chk("dm_err", dm_err, 32'(is_dm && !legal));
        tick();
        dm_req = 1'b0;
        if (!is_dm) if_req = 1'b0;
        if (!legal) begin
            chk("err_no_memreq", mem_req, 32'h0);
            return;
        end
        word   = rd_word(addr >> 2);
        exp_be = st ? 32'h0 : 32'hF;
        exp_wd = 32'h0;
        if (st)
            for (int i = 0; i < 4; i++) begin
                if (i >= a && i < a + nb) exp_be[i] = 1'b1;
                exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
        chk("mem_req", mem_req, 32'h1);
        chk("mem_we", mem_we, 32'(st));
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_be", mem_be, exp_be);
        chk("mem_wdata", mem_wdata, exp_wd);
        for (int i = 0; i < dr; i++) begin
            tick();
            chk("memreq_held", mem_req, 32'h1);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("memreq_drop", mem_req, 32'h0);
        for (int i = 0; i < dv; i++) begin
            tick();
            chk("rvalid_wait", 32'(dm_rvalid | if_rvalid), 32'h0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (!is_dm)  exp_rd = word;
        else if (st) exp_rd = 32'h0;
        else begin
            v = word >> (8 * a);
            if (nb == 1) begin
                v = v & 32'hFF;
                if (!size[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (nb == 2) begin
                v = v & 32'hFFFF;
                if (!size[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            exp_rd = v;
        end
        chk("dm_rvalid", dm_rvalid, 32'(is_dm));
        chk("if_rvalid", if_rvalid, 32'(!is_dm));
        got = is_dm ? dm_rdata : if_rdata;
        chk(is_dm ? "dm_rdata" : "if_rdata", got, exp_rd);
        chk("done_no_gnt", 32'(if_gnt | dm_gnt), 32'h0);
        if (st) begin
            for (int i = 0; i < 4; i++)
                if (i >= a && i < a + nb) word[8*i +: 8] = wd[8*(i - a) +: 8];
            mem_m[addr >> 2] = word;
        end
        tick();
        chk("rvalid_pulse", 32'(dm_rvalid | if_rvalid), 32'h0);
    endtask

    initial begin
        logic [31:0] got;
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_size = 3'b0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 32'h0);
        chk("rst_rvalid", 32'(if_rvalid | dm_rvalid), 32'h0);
        chk("rst_err_timeout", err_timeout, 32'h0);
        chk("rst_mem_be", mem_be, 32'h0);
        rst_n = 1'b1;
        tick();

        // Simultaneous requests: data first, fetch granted in the IDLE after DONE.
        if_req = 1'b1; if_addr = 32'h40;
        txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, got);
        chk("if_gnt_after_done", if_gnt, 32'h1);
        txn(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 0, 0, got);

        txn(1'b1, 1'b1, 3'b000, 32'h203, 32'h0000_00AB, 0, 0, got);
        chk("sb_merged", mem_m[32'h203 >> 2] >> 24, 32'hAB);

        mem_m[32'h300 >> 2] = 32'h80F0_7F01;
        txn(1'b1, 1'b0, 3'b000, 32'h303, 32'h0, 1, 0, got); chk("t3_lb",  got, 32'hFFFF_FF80);
        txn(1'b1, 1'b0, 3'b100, 32'h303, 32'h0, 0, 1, got); chk("t3_lbu", got, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 2, 2, got); chk("t3_lh",  got, 32'hFFFF_80F0);
        txn(1'b1, 1'b0, 3'b101, 32'h300, 32'h0, 0, 0, got); chk("t3_lhu", got, 32'h0000_7F01);

        txn(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, got);
        txn(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, got);

        // Hung memory: abort exactly TIMEOUT cycles after entering REQ.
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 3'b010; dm_addr = 32'h500;
        tick();
        dm_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("wd_not_yet", err_timeout, 32'h0);
        chk("wd_memreq_held", mem_req, 32'h1);
        tick();
        chk("wd_err", err_timeout, 32'h1);
        chk("wd_rvalid", dm_rvalid, 32'h1);
        chk("wd_rdata", dm_rdata, 32'h0);
        chk("wd_memreq_drop", mem_req, 32'h0);
        tick();
        chk("wd_idle_rvalid", dm_rvalid, 32'h0);
        txn(1'b0, 1'b0, 3'b010, 32'h80, 32'h0, 0, 0, got);
        chk("wd_sticky", err_timeout, 32'h1);

        for (int k = 0; k < 40; k++)
            txn(($urandom % 3) != 0, $urandom % 2, 3'($urandom % 8), 32'h100 + ($urandom % 64),
                $urandom, int'($urandom % 3), int'($urandom % 3), got);

        // Reset while in RESP, then a late mem_rvalid in IDLE.
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        if_req = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 32'h0);
        chk("arst_err", err_timeout, 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_rvalid", 32'(if_rvalid | dm_rvalid), 32'h0);
        tick();
        rst_n = 1'b1; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_ignored", 32'(if_rvalid | mem_req), 32'h0);
        txn(1'b0, 1'b0, 3'b010, 32'h404, 32'h0, 1, 1, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
